// File: rtl/dma_csr_axil_slave.sv
// dma_csr_axil_slave: AXI4-Lite register map for the DMA engine.
// Holds the transfer configuration, issues the start pulse and gathers completion/error status into an interrupt.
module dma_csr_axil_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   src_addr_o,
    output logic [DATA_W-1:0]   dst_addr_o,
    output logic [DATA_W-1:0]   length_o,
    output logic [1:0]          burst_o,
    output logic                start_o,
    input  logic                busy_i,
    input  logic                done_i,
    input  logic                err_i,
    output logic                irq_o
);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                rdy_q;
    logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, rmux;
    logic [DATA_W-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic                irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
    logic                start_q, start_d, irq_q, irq_d;
    logic                wr_fire, start_ok;
    logic [2:0]          widx;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [DATA_W/8-1:0] s);
        merge = old;
        for (int i = 0; i < DATA_W/8; i++)
            if (s[i]) merge[i*8 +: 8] = d[i*8 +: 8];
    endfunction

    assign s_awready  = rdy_q & ~aw_held_q & ~bvalid_q;
    assign s_wready   = rdy_q & ~w_held_q & ~bvalid_q;
    assign s_arready  = rdy_q & ~rvalid_q;
    assign s_bvalid   = bvalid_q;
    assign s_bresp    = bresp_q;
    assign s_rvalid   = rvalid_q;
    assign s_rresp    = rresp_q;
    assign s_rdata    = rdata_q;
    assign src_addr_o = src_q;
    assign dst_addr_o = dst_q;
    assign length_o   = len_q;
    assign burst_o    = burst_q;
    assign start_o    = start_q;
    assign irq_o      = irq_q;

    assign wr_fire  = aw_held_q & w_held_q & ~bvalid_q;
    assign widx     = aw_addr_q[4:2];
    assign start_ok = ~busy_i & (|len_q) & (burst_q != 2'b11);

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        burst_d   = burst_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        start_d   = 1'b0;
        irq_d     = irq_en_q & (done_q | err_q);
        rmux      = '0;
        if (s_awvalid && s_awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_held_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = OKAY;
            // Address registers are frozen while the engine runs; the full compare also catches 0x20+.
            if (!(aw_addr_q < ADDR_W'(24)) || (busy_i && widx < 3'd3)) bresp_d = SLVERR;
            else case (widx)
                3'd0: src_d = merge(src_q, w_data_q, w_strb_q);
                3'd1: dst_d = merge(dst_q, w_data_q, w_strb_q);
                3'd2: len_d = merge(len_q, w_data_q, w_strb_q);
                3'd3: if (w_strb_q[0]) begin
                    irq_en_d = w_data_q[1];
                    if (w_data_q[0] && start_ok) begin
                        start_d = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else if (w_data_q[0]) begin
                        err_d   = 1'b1;
                        bresp_d = SLVERR;
                    end
                end
                3'd4: if (w_strb_q[0]) begin
                    done_d = done_q & ~w_data_q[0];
                    err_d  = err_q & ~w_data_q[1];
                end
                3'd5: if (w_strb_q[0]) burst_d = w_data_q[1:0];
                default: ;
            endcase
        end
        if (bvalid_q && s_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        // Hardware events land after the W1C so a same-cycle set is never lost.
        if (done_i) done_d = 1'b1;
        if (err_i) err_d = 1'b1;
        case (s_araddr[4:2])
            3'd0: rmux = src_q;
            3'd1: rmux = dst_q;
            3'd2: rmux = len_q;
            3'd3: rmux[1] = irq_en_q;
            3'd4: rmux[2:0] = {busy_i, err_q, done_q};
            3'd5: rmux[1:0] = burst_q;
            default: ;
        endcase
        if (s_arvalid && s_arready) begin
            rvalid_d = 1'b1;
            rresp_d  = (s_araddr < ADDR_W'(24)) ? OKAY : SLVERR;
            rdata_d  = (s_araddr < ADDR_W'(24)) ? rmux : '0;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            burst_q   <= 2'b01;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_dma_csr_axil_slave.sv
// tb_dma_csr_axil_slave: directed AXI4-Lite transactions against the DMA register map.
module tb_dma_csr_axil_slave;
    logic        clk, rst_n;
    logic [7:0]  s_awaddr, s_araddr;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp, burst_o;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] src_addr_o, dst_addr_o, length_o;
    logic        start_o, busy_i, done_i, err_i, irq_o;
    int          total, bad, start_cnt;
    logic [1:0]  resp;
    logic [31:0] rd;

    dma_csr_axil_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .length_o(length_o),
        .burst_o(burst_o), .start_o(start_o), .busy_i(busy_i), .done_i(done_i),
        .err_i(err_i), .irq_o(irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start_o) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        logic aw_ok, w_ok;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0; n = 0;
        while ((s_awvalid || s_wvalid) && n < 20) begin
            @(negedge clk);
            aw_ok = s_awvalid & s_awready;
            w_ok  = s_wvalid & s_wready;
            @(posedge clk); #1;
            if (aw_ok) s_awvalid = 1'b0;
            if (w_ok) s_wvalid = 1'b0;
            n++;
        end
        while (!s_bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_timeout", 32'(n < 20), 1);
        r = s_bresp;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        logic ar_ok;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0; n = 0; ar_ok = 1'b0;
        while (!ar_ok && n < 20) begin
            @(negedge clk);
            ar_ok = s_arready;
            @(posedge clk); #1;
            n++;
        end
        s_arvalid = 1'b0;
        while (!s_rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_timeout", 32'(n < 20), 1);
        d = s_rdata; r = s_rresp;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; start_cnt = 0;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0; busy_i = 0; done_i = 0; err_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", s_awready, 0);
        chk("rst_burst", burst_o, 2'b01);
        chk("rst_start", start_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("awready_up", s_awready, 1);
        chk("arready_up", s_arready, 1);

        axi_read(8'h14, rd, resp);
        chk("rst_burst_rd", rd, 32'h1);
        chk("rst_burst_resp", resp, 2'b00);
        axi_read(8'h00, rd, resp);
        chk("rst_src_rd", rd, 32'h0);
        chk("rst_irq", irq_o, 0);

        // AW leads W by three cycles, bready held low
        s_bready = 1'b0; s_awaddr = 8'h08; s_awvalid = 1'b1;
        @(negedge clk); chk("aw_ready", s_awready, 1);
        @(posedge clk); #1; s_awvalid = 1'b0;
        chk("aw_held_blocks", s_awready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("no_early_b", s_bvalid, 0);
        s_wdata = 32'h100; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk); chk("w_ready", s_wready, 1);
        @(posedge clk); #1; s_wvalid = 1'b0;
        chk("b_not_yet", s_bvalid, 0);
        @(posedge clk); #1;
        chk("b_rise", s_bvalid, 1);
        chk("len_written", length_o, 32'h100);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("b_hold", s_bvalid, 1);
        end
        chk("b_okay", s_bresp, 2'b00);
        chk("aw_blocked_b", s_awready, 0);
        s_bready = 1'b1;
        @(posedge clk); #1; s_bready = 1'b0;
        chk("b_drop", s_bvalid, 0);

        axi_write(8'h00, 32'hAABBCCDD, 4'hF, resp);
        axi_write(8'h00, 32'h11223344, 4'b0101, resp);
        chk("partial_strb", src_addr_o, 32'hAA22CC44);

        axi_write(8'h08, 32'h40, 4'hF, resp);
        axi_write(8'h14, 32'h1, 4'hF, resp);
        start_cnt = 0;
        axi_write(8'h0C, 32'h3, 4'hF, resp);
        chk("start_resp", resp, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("start_once", start_cnt, 1);
        done_i = 1'b1;
        @(posedge clk); #1; done_i = 1'b0;
        chk("irq_lag", irq_o, 0);
        @(posedge clk); #1;
        chk("irq_set", irq_o, 1);
        axi_read(8'h10, rd, resp);
        chk("status_done", rd, 32'h1);
        axi_read(8'h0C, rd, resp);
        chk("ctrl_rd", rd, 32'h2);
        axi_write(8'h10, 32'h1, 4'hF, resp);
        chk("irq_clr", irq_o, 0);

        axi_write(8'h14, 32'hFFFF_FFFE, 4'hF, resp);
        axi_read(8'h14, rd, resp);
        chk("burst_mask", rd, 32'h2);
        axi_write(8'h14, 32'h1, 4'hF, resp);

        // rejected starts
        axi_write(8'h08, 32'h0, 4'hF, resp);
        start_cnt = 0;
        axi_write(8'h0C, 32'h1, 4'hF, resp);
        chk("rej_len_resp", resp, 2'b10);
        axi_read(8'h10, rd, resp);
        chk("rej_len_err", rd, 32'h2);
        axi_write(8'h10, 32'h2, 4'hF, resp);
        axi_write(8'h08, 32'h80, 4'hF, resp);
        busy_i = 1'b1;
        axi_write(8'h0C, 32'h1, 4'hF, resp);
        chk("rej_busy_resp", resp, 2'b10);
        axi_read(8'h10, rd, resp);
        chk("rej_busy_stat", rd, 32'h6);
        axi_write(8'h04, 32'h1234, 4'hF, resp);
        chk("dst_busy_resp", resp, 2'b10);
        chk("dst_busy_keep", dst_addr_o, 32'h0);
        chk("rej_no_start", start_cnt, 0);
        busy_i = 1'b0;

        // err_i coincides with the W1C edge
        s_awaddr = 8'h10; s_wdata = 32'h2; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; err_i = 1'b1;
        @(posedge clk); #1;
        err_i = 1'b0;
        chk("coll_b", s_bvalid, 1);
        s_bready = 1'b1;
        @(posedge clk); #1; s_bready = 1'b0;
        axi_read(8'h10, rd, resp);
        chk("coll_set_wins", rd, 32'h2);
        axi_write(8'h10, 32'h2, 4'hF, resp);
        axi_read(8'h10, rd, resp);
        chk("w1c_err", rd, 32'h0);

        axi_read(8'h1C, rd, resp);
        chk("unmap_rdata", rd, 32'h0);
        chk("unmap_rresp", resp, 2'b10);
        axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, resp);
        chk("unmap_bresp", resp, 2'b10);

        // reset while a B response is pending
        s_awaddr = 8'h00; s_wdata = 32'h55; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_b", s_bvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_b", s_bvalid, 0);
        chk("mid_rst_src", src_addr_o, 32'h0);
        chk("mid_rst_len", length_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_csr_axil_slave.md
Name: dma_csr_axil_slave

Overview:
AXI4-Lite responder that implements the DMA controller's programmer-visible register map: SRC_ADDR 0x00, DST_ADDR 0x04, LENGTH 0x08, CONTROL 0x0C, STATUS 0x10 and BURST 0x14. It sits between the host interconnect and the DMA datapath engine. It turns host writes into configuration outputs and a one-cycle start pulse. It collects engine completion and error events into sticky status bits and drives a level interrupt.

Parameters:
ADDR_W, 8, AXI-Lite address width; decode uses addr[4:2], and addr[1:0] is ignored.
DATA_W, 32, AXI-Lite data width (fixed 32; wstrb is DATA_W/8).

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
s_awaddr  input  ADDR_W  write address
s_awvalid  input  1  write address valid
s_awready  output  1  write address ready
s_wdata  input  32  write data
s_wstrb  input  4  byte strobes
s_wvalid  input  1  write data valid
s_wready  output  1  write data ready
s_bresp  output  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  output  1  write response valid
s_bready  input  1  write response ready
s_araddr  input  ADDR_W  read address
s_arvalid  input  1  read address valid
s_arready  output  1  read address ready
s_rdata  output  32  read data
s_rresp  output  2  read response
s_rvalid  output  1  read data valid
s_rready  input  1  read data ready
src_addr_o  output  32  configured source address
dst_addr_o  output  32  configured destination address
length_o  output  32  configured byte count
burst_o  output  2  00 FIXED, 01 INCR, 10 WRAP
start_o  output  1  one-cycle start pulse to the engine
busy_i  input  1  engine transfer in progress
done_i  input  1  one-cycle completion pulse
err_i  input  1  one-cycle error pulse
irq_o  output  1  registered interrupt level

Behaviour:
- Reset values: all AXI valid/ready outputs 0; bresp, rresp and rdata 0; src, dst and length 0; burst_o 2'b01; irq_en 0; done 0; err 0; start_o 0; irq_o 0. awready, wready and arready go to 1 on the first cycle after reset release.
- Write channel:
  - AW and W are accepted independently, in either order or together.
  - awready=1 while no AW is held and bvalid=0; wready follows the same rule for W.
  - Once both AW and W are held, the register update occurs on that edge, and bvalid rises on the next cycle.
  - bvalid holds until bready; the held AW/W are cleared on the B handshake.
  - No new write is accepted while bvalid=1.
- Read channel:
  - arready=1 while rvalid=0.
  - On the AR handshake, rdata and rresp are registered, and rvalid rises on the next cycle.
  - rvalid and rdata hold until rready.
  - Reads and writes proceed concurrently.
- SRC, DST, LENGTH: read/write, with per-byte wstrb honoured. A write while busy_i=1 is dropped with SLVERR.
- BURST: bits [1:0] are read/write, updated if wstrb[0]=1; upper bits read 0. Value 2'b11 is stored.
- CONTROL write (byte 0 strobe required):
  - bit1 updates irq_en.
  - bit0=1 requests a start. start_o pulses for exactly one cycle, on the cycle after the write edge, only if busy_i=0, length!=0 and burst!=2'b11.
  - If the start is rejected: no pulse, err is set, and bresp=SLVERR.
  - An accepted start clears done and err on the same edge.
- CONTROL read: bit0 reads 0, bit1 = irq_en.
- STATUS read: bit0 done, bit1 err, bit2 busy_i, others 0.
- STATUS write: bits 0 and 1 are write-1-to-clear. If a hardware set (done_i/err_i) and a W1C occur in the same cycle, the set wins.
- done_i=1 sets done; err_i=1 sets err. Both bits are sticky.
- irq_o is registered: irq_o <= irq_en & (done | err). Latency is one cycle after the status bit changes.
- Unmapped offsets (0x18 and above): write is ignored with SLVERR; read returns 0 with SLVERR.
- Reset asserted mid-transaction: all state is cleared immediately, any pending B/R response is discarded, and start_o is forced to 0.

Test Plan:
- Reset check: release rst_n, then read 0x14 -> rdata=0x1, OKAY; read 0x00 -> 0x0; irq_o=0.
- AW-before-W: drive AW 0x08 three cycles before W 0x0000_0100 (wstrb=F) -> single write, length_o=0x100, bvalid one cycle after the W handshake, OKAY; hold bready=0 for 4 cycles -> bvalid stays high.
- Partial strobe: write SRC=0xAABBCCDD, then write 0x11223344 with wstrb=4'b0101 -> src_addr_o=0xAA22CC44.
- Start flow: length=0x40, burst=01, CONTROL=0x3 -> start_o high exactly 1 cycle. Pulse done_i -> STATUS reads 0x1 and irq_o=1 one cycle later. W1C STATUS=0x1 -> irq_o=0.
- Rejected starts:
  - CONTROL=0x1 with length=0 -> no start_o pulse, SLVERR, STATUS bit1=1.
  - CONTROL=0x1 while busy_i=1 -> no start_o pulse, SLVERR, STATUS bit1=1.
  - Write DST while busy -> SLVERR, dst_addr_o unchanged.
- Collisions: err_i pulse in the same cycle as W1C STATUS=0x2 -> err remains 1. Read 0x1C -> rdata=0, rresp=2'b10.
